// File: rtl/id_stage_fwd_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings, AluOp/AluSel codes
// and the NOP codes that fill a bubble in the ID/EX register.
package id_stage_fwd_pkg;

  localparam int ALUOP_W  = 8;
  localparam int ALUSEL_W = 3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP  = 8'h00,
    ALU_SRL  = 8'h02,
    ALU_ADDU = 8'h21,
    ALU_SUBU = 8'h23,
    ALU_AND  = 8'h24,
    ALU_OR   = 8'h25,
    ALU_XOR  = 8'h26,
    ALU_NOR  = 8'h27,
    ALU_SLT  = 8'h2a,
    ALU_SLL  = 8'h7c,
    ALU_LW   = 8'he3,
    ALU_SW   = 8'heb
  } alu_op_e;

  typedef enum logic [ALUSEL_W-1:0] {
    SEL_NOP   = 3'd0,
    SEL_LOGIC = 3'd1,
    SEL_SHIFT = 3'd2,
    SEL_ARITH = 3'd4,
    SEL_LDST  = 3'd7
  } alu_sel_e;

endpackage

// File: rtl/id_stage_fwd_if.sv
// ID/EX register interface: the decoded bundle towards EX plus EX's ready/flush.
// Handshake: the register advances on every clock where ready=1 (valid may be 0,
// which is a bubble); with ready=0 all fields hold and flush is ignored.
interface id_stage_fwd_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
);
  import id_stage_fwd_pkg::*;

  logic              ready;
  logic              flush;
  logic              valid;
  logic [ADDR_W-1:0] pc;
  alu_op_e           aluop;
  alu_sel_e          alusel;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic [DATA_W-1:0] sdata;
  logic [REG_AW-1:0] wd;
  logic              wreg;

  modport master (input ready, flush,
                  output valid, pc, aluop, alusel, reg1, reg2, sdata, wd, wreg);
  modport slave  (output ready, flush,
                  input valid, pc, aluop, alusel, reg1, reg2, sdata, wd, wreg);
endinterface

// File: rtl/id_stage_fwd_decode.sv
// Combinational MIPS decoder: instruction word to ALU codes, register-read
// requests, immediate operands and destination; flags unknown encodings.
module id_stage_fwd_decode
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       inst,
  output alu_op_e           aluop,
  output alu_sel_e          alusel,
  output logic              reg1_read,
  output logic              reg2_read,
  output logic [REG_AW-1:0] reg1_addr,
  output logic [REG_AW-1:0] reg2_addr,
  output logic [DATA_W-1:0] op1_imm,
  output logic              op1_use_imm,
  output logic [DATA_W-1:0] op2_imm,
  output logic              op2_use_imm,
  output logic              is_store,
  output logic [REG_AW-1:0] wd,
  output logic              wreg,
  output logic              illegal
);
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign opcode    = inst[31:26];
  assign funct     = inst[5:0];
  assign imm16     = inst[15:0];
  assign reg1_addr = REG_AW'(inst[25:21]);
  assign reg2_addr = REG_AW'(inst[20:16]);
  assign op1_imm   = DATA_W'(inst[10:6]);

  always_comb begin
    aluop       = ALU_NOP;
    alusel      = SEL_NOP;
    reg1_read   = 1'b0;
    reg2_read   = 1'b0;
    op1_use_imm = 1'b0;
    op2_imm     = '0;
    op2_use_imm = 1'b0;
    is_store    = 1'b0;
    wd          = REG_AW'(inst[20:16]);
    wreg        = 1'b0;
    illegal     = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        // The all-zero word is the canonical NOP: valid slot, no register effect.
        if (inst != 32'h0) begin
          case (funct)
            FN_SLL:  begin aluop = ALU_SLL;  alusel = SEL_SHIFT; end
            FN_SRL:  begin aluop = ALU_SRL;  alusel = SEL_SHIFT; end
            FN_ADDU: begin aluop = ALU_ADDU; alusel = SEL_ARITH; end
            FN_SUBU: begin aluop = ALU_SUBU; alusel = SEL_ARITH; end
            FN_SLT:  begin aluop = ALU_SLT;  alusel = SEL_ARITH; end
            FN_AND:  begin aluop = ALU_AND;  alusel = SEL_LOGIC; end
            FN_OR:   begin aluop = ALU_OR;   alusel = SEL_LOGIC; end
            FN_XOR:  begin aluop = ALU_XOR;  alusel = SEL_LOGIC; end
            FN_NOR:  begin aluop = ALU_NOR;  alusel = SEL_LOGIC; end
            default: illegal = 1'b1;
          endcase
          wd          = REG_AW'(inst[15:11]);
          wreg        = !illegal;
          reg2_read   = !illegal;
          reg1_read   = !illegal && (alusel != SEL_SHIFT);
          op1_use_imm = (alusel == SEL_SHIFT);
        end
      end
      OP_ORI, OP_ANDI, OP_XORI: begin
        aluop       = (opcode == OP_ORI)  ? ALU_OR :
                      (opcode == OP_ANDI) ? ALU_AND : ALU_XOR;
        alusel      = SEL_LOGIC;
        reg1_read   = 1'b1;
        op2_imm     = DATA_W'(imm16);
        op2_use_imm = 1'b1;
        wreg        = 1'b1;
      end
      OP_ADDIU, OP_LW, OP_SW: begin
        aluop       = (opcode == OP_ADDIU) ? ALU_ADDU :
                      (opcode == OP_LW)    ? ALU_LW : ALU_SW;
        alusel      = (opcode == OP_ADDIU) ? SEL_ARITH : SEL_LDST;
        reg1_read   = 1'b1;
        reg2_read   = (opcode == OP_SW);
        is_store    = (opcode == OP_SW);
        op2_imm     = {{(DATA_W-16){imm16[15]}}, imm16};
        op2_use_imm = 1'b1;
        wreg        = (opcode != OP_SW);
      end
      OP_LUI: begin
        aluop       = ALU_OR;
        alusel      = SEL_LOGIC;
        op2_imm     = DATA_W'({imm16, 16'h0});
        op2_use_imm = 1'b1;
        wreg        = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Decode stage: register read with EX/MEM forwarding, load-use hazard stall,
// and the ID/EX pipeline register with ready/flush control and a stall counter.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [31:0]       inst_i,
  input  logic              if_valid_i,
  output logic              id_ready_o,
  output logic              reg1_read_o,
  output logic [REG_AW-1:0] reg1_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  output logic              reg2_read_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wd_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic              ex_is_load_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wd_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  id_stage_fwd_if.master    ex_bus,
  output logic              illegal_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam bit FWD_ON = (FWD_EN != 0);

  alu_op_e           dec_aluop;
  alu_sel_e          dec_alusel;
  logic [DATA_W-1:0] dec_op1_imm, dec_op2_imm;
  logic              dec_op1_use_imm, dec_op2_use_imm, dec_store;
  logic [REG_AW-1:0] dec_wd;
  logic              dec_wreg, dec_illegal;

  id_stage_fwd_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_decode (
    .inst        (inst_i),
    .aluop       (dec_aluop),
    .alusel      (dec_alusel),
    .reg1_read   (reg1_read_o),
    .reg2_read   (reg2_read_o),
    .reg1_addr   (reg1_addr_o),
    .reg2_addr   (reg2_addr_o),
    .op1_imm     (dec_op1_imm),
    .op1_use_imm (dec_op1_use_imm),
    .op2_imm     (dec_op2_imm),
    .op2_use_imm (dec_op2_use_imm),
    .is_store    (dec_store),
    .wd          (dec_wd),
    .wreg        (dec_wreg),
    .illegal     (dec_illegal)
  );

  // Youngest producer wins: EX result over MEM result over the register file.
  function automatic logic [DATA_W-1:0] pick(input logic rd, input logic [REG_AW-1:0] a,
                                             input logic [DATA_W-1:0] rf_data);
    if (!rd || a == '0)                              return '0;
    if (FWD_ON && ex_wreg_i && ex_wd_i == a)         return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == a)                 return mem_wdata_i;
    return rf_data;
  endfunction

  // A load in EX has no data yet; without forwarding any in-flight write blocks.
  function automatic logic raw_stall(input logic rd, input logic [REG_AW-1:0] a);
    logic ex_hit, mem_hit;
    ex_hit  = ex_wreg_i && (ex_wd_i == a);
    mem_hit = mem_wreg_i && (mem_wd_i == a);
    return rd && (a != '0) && ((ex_hit && (ex_is_load_i || !FWD_ON)) || (mem_hit && !FWD_ON));
  endfunction

  logic [DATA_W-1:0] op1, op2;
  logic              hazard, take;

  always_comb begin
    op1    = pick(reg1_read_o, reg1_addr_o, reg1_data_i);
    op2    = pick(reg2_read_o, reg2_addr_o, reg2_data_i);
    hazard = if_valid_i && (raw_stall(reg1_read_o, reg1_addr_o) ||
                            raw_stall(reg2_read_o, reg2_addr_o));
    take   = !ex_bus.flush && !hazard && if_valid_i && !dec_illegal;
  end

  assign id_ready_o = ex_bus.ready && !hazard;

  logic              valid_q, wreg_q, illegal_q;
  logic [ADDR_W-1:0] pc_q;
  alu_op_e           aluop_q;
  alu_sel_e          alusel_q;
  logic [DATA_W-1:0] reg1_q, reg2_q, sdata_q;
  logic [REG_AW-1:0] wd_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      aluop_q   <= ALU_NOP;
      alusel_q  <= SEL_NOP;
      reg1_q    <= '0;
      reg2_q    <= '0;
      sdata_q   <= '0;
      wd_q      <= '0;
      wreg_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      illegal_q <= 1'b0;
      if (ex_bus.ready) begin
        valid_q   <= take;
        pc_q      <= take ? pc_i : '0;
        aluop_q   <= take ? dec_aluop : ALU_NOP;
        alusel_q  <= take ? dec_alusel : SEL_NOP;
        reg1_q    <= !take ? '0 : (dec_op1_use_imm ? dec_op1_imm : op1);
        reg2_q    <= !take ? '0 : (dec_op2_use_imm ? dec_op2_imm : op2);
        sdata_q   <= (take && dec_store) ? op2 : '0;
        wd_q      <= take ? dec_wd : '0;
        wreg_q    <= take && dec_wreg;
        illegal_q <= !ex_bus.flush && !hazard && if_valid_i && dec_illegal;
        if (!ex_bus.flush && hazard && cnt_q != '1)
          cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign ex_bus.valid  = valid_q;
  assign ex_bus.pc     = pc_q;
  assign ex_bus.aluop  = aluop_q;
  assign ex_bus.alusel = alusel_q;
  assign ex_bus.reg1   = reg1_q;
  assign ex_bus.reg2   = reg2_q;
  assign ex_bus.sdata  = sdata_q;
  assign ex_bus.wd     = wd_q;
  assign ex_bus.wreg   = wreg_q;
  assign illegal_o     = illegal_q;
  assign stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_id_stage_fwd.sv
// Bench for id_stage_fwd: table-driven reference model of decode, forwarding,
// hazard and ID/EX update, checked every cycle, plus directed literal checks.
module tb_id_stage_fwd;
  import id_stage_fwd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc, inst;
  logic        if_valid, id_ready;
  logic        reg1_read, reg2_read;
  logic [4:0]  reg1_addr, reg2_addr;
  logic [31:0] reg1_data, reg2_data;
  logic        ex_wreg, ex_is_load, mem_wreg, illegal;
  logic [4:0]  ex_wd, mem_wd;
  logic [31:0] ex_wdata, mem_wdata;
  logic [15:0] stall_cnt;
  logic [31:0] rf [32];

  id_stage_fwd_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(5)) bus ();

  id_stage_fwd dut (
    .clk(clk), .rst(rst), .pc_i(pc), .inst_i(inst), .if_valid_i(if_valid),
    .id_ready_o(id_ready),
    .reg1_read_o(reg1_read), .reg1_addr_o(reg1_addr), .reg1_data_i(reg1_data),
    .reg2_read_o(reg2_read), .reg2_addr_o(reg2_addr), .reg2_data_i(reg2_data),
    .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
    .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
    .ex_bus(bus), .illegal_o(illegal), .stall_cnt_o(stall_cnt)
  );

  // Register file environment: combinational read.
  assign reg1_data = rf[reg1_addr];
  assign reg2_data = rf[reg2_addr];

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [5:0] op; logic [5:0] fn; logic [7:0] aluop; logic [2:0] sel;
    logic rd1, rd2, sh1, st, wreg, rtype; logic [1:0] immk;  // 1 zext, 2 sext, 3 hi
  } row_t;

  typedef struct packed {
    logic valid; logic [31:0] pc; logic [7:0] aluop; logic [2:0] alusel;
    logic [31:0] r1, r2, sd; logic [4:0] wd; logic wreg;
  } bund_t;

  row_t  tbl [16];
  bund_t m     = '0;
  logic  m_ill = 1'b0;
  logic [15:0] m_cnt = 16'h0;

  initial begin
    tbl[0]  = '{6'h0d, 6'h00, 8'(ALU_OR),   3'(SEL_LOGIC), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[1]  = '{6'h0c, 6'h00, 8'(ALU_AND),  3'(SEL_LOGIC), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[2]  = '{6'h0e, 6'h00, 8'(ALU_XOR),  3'(SEL_LOGIC), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1};
    tbl[3]  = '{6'h09, 6'h00, 8'(ALU_ADDU), 3'(SEL_ARITH), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[4]  = '{6'h0f, 6'h00, 8'(ALU_OR),   3'(SEL_LOGIC), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3};
    tbl[5]  = '{6'h23, 6'h00, 8'(ALU_LW),   3'(SEL_LDST),  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2};
    tbl[6]  = '{6'h2b, 6'h00, 8'(ALU_SW),   3'(SEL_LDST),  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2};
    tbl[7]  = '{6'h00, 6'h00, 8'(ALU_SLL),  3'(SEL_SHIFT), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[8]  = '{6'h00, 6'h02, 8'(ALU_SRL),  3'(SEL_SHIFT), 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[9]  = '{6'h00, 6'h21, 8'(ALU_ADDU), 3'(SEL_ARITH), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[10] = '{6'h00, 6'h23, 8'(ALU_SUBU), 3'(SEL_ARITH), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[11] = '{6'h00, 6'h24, 8'(ALU_AND),  3'(SEL_LOGIC), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[12] = '{6'h00, 6'h25, 8'(ALU_OR),   3'(SEL_LOGIC), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[13] = '{6'h00, 6'h26, 8'(ALU_XOR),  3'(SEL_LOGIC), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[14] = '{6'h00, 6'h27, 8'(ALU_NOR),  3'(SEL_LOGIC), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
    tbl[15] = '{6'h00, 6'h2a, 8'(ALU_SLT),  3'(SEL_ARITH), 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0};
  end

  function automatic void lookup(input logic [31:0] i, output row_t r, output logic legal);
    r = '0;
    legal = (i == 32'h0);
    if (i != 32'h0)
      for (int k = 0; k < 16; k++)
        if (tbl[k].op == i[31:26] && (!tbl[k].rtype || tbl[k].fn == i[5:0])) begin
          r = tbl[k];
          legal = 1'b1;
        end
  endfunction

  function automatic logic [31:0] opnd(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (ex_wreg && ex_wd == a) return ex_wdata;
    if (mem_wreg && mem_wd == a) return mem_wdata;
    return rf[a];
  endfunction

  function automatic logic m_hazard(input row_t r);
    logic h1, h2;
    h1 = r.rd1 && inst[25:21] != 5'd0 && ex_wreg && ex_wd == inst[25:21] && ex_is_load;
    h2 = r.rd2 && inst[20:16] != 5'd0 && ex_wreg && ex_wd == inst[20:16] && ex_is_load;
    return if_valid && (h1 || h2);
  endfunction

  function automatic bund_t m_bundle(input row_t r);
    bund_t b;
    logic [15:0] imm;
    imm = inst[15:0];
    b = '0;
    b.valid = 1'b1; b.pc = pc; b.aluop = r.aluop; b.alusel = r.sel;
    b.r1 = r.sh1 ? {27'h0, inst[10:6]} : (r.rd1 ? opnd(inst[25:21]) : 32'h0);
    case (r.immk)
      2'd1:    b.r2 = {16'h0, imm};
      2'd2:    b.r2 = {{16{imm[15]}}, imm};
      2'd3:    b.r2 = {imm, 16'h0};
      default: b.r2 = r.rd2 ? opnd(inst[20:16]) : 32'h0;
    endcase
    b.sd   = r.st ? opnd(inst[20:16]) : 32'h0;
    b.wd   = r.rtype ? inst[15:11] : inst[20:16];
    b.wreg = r.wreg;
    return b;
  endfunction

  always @(posedge clk or negedge rst) begin
    row_t r;
    logic lg, hz;
    if (!rst) begin
      m = '0; m_ill = 1'b0; m_cnt = 16'h0;
    end else begin
      lookup(inst, r, lg);
      hz = m_hazard(r);
      m_ill = 1'b0;
      if (bus.ready) begin
        if (bus.flush || hz || !if_valid || !lg) m = '0;
        else m = m_bundle(r);
        m_ill = !bus.flush && !hz && if_valid && !lg;
        if (!bus.flush && hz && m_cnt != 16'hffff) m_cnt = m_cnt + 16'd1;
      end
    end
  end

  // Compare process: registered state and combinational outputs every cycle.
  always @(negedge clk) begin
    row_t r;
    logic lg;
    lookup(inst, r, lg);
    check("ex_valid",  bus.valid,  m.valid);
    check("ex_pc",     bus.pc,     m.pc);
    check("ex_aluop",  bus.aluop,  m.aluop);
    check("ex_alusel", bus.alusel, m.alusel);
    check("ex_reg1",   bus.reg1,   m.r1);
    check("ex_reg2",   bus.reg2,   m.r2);
    check("ex_sdata",  bus.sdata,  m.sd);
    check("ex_wd",     bus.wd,     m.wd);
    check("ex_wreg",   bus.wreg,   m.wreg);
    check("illegal",   illegal,    m_ill);
    check("stall_cnt", stall_cnt,  m_cnt);
    check("id_ready",  id_ready,   bus.ready && !m_hazard(r));
    check("reg1_read", reg1_read,  r.rd1);
    check("reg2_read", reg2_read,  r.rd2);
    check("reg1_addr", reg1_addr,  inst[25:21]);
    check("reg2_addr", reg2_addr,  inst[20:16]);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [4:0]  rs, rt, rd, sh;
    logic [15:0] imm;
    logic [5:0]  fn;
    int          kind;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7)); sh = 5'($urandom);
    imm = 16'($urandom); kind = $urandom_range(0, 17);
    if (kind <= 6) return {tbl[kind].op, rs, rt, imm};
    if (kind <= 15) begin
      fn = tbl[kind].fn;
      return {6'h00, rs, rt, rd, sh, fn};
    end
    if (kind == 16) return 32'h0;
    return ($urandom_range(0, 1) == 0) ? {6'h3f, 26'($urandom)} : {6'h00, rs, rt, rd, sh, 6'h3f};
  endfunction

  task automatic quiet_fwd();
    ex_wreg = 1'b0; ex_wd = 5'd0; ex_wdata = 32'h0; ex_is_load = 1'b0;
    mem_wreg = 1'b0; mem_wd = 5'd0; mem_wdata = 32'h0;
  endtask

  initial begin
    for (int k = 0; k < 32; k++) rf[k] = $urandom;
    pc = 32'h0; inst = 32'h0; if_valid = 1'b0;
    bus.ready = 1'b1; bus.flush = 1'b0;
    quiet_fwd();
    repeat (2) step();
    check("rst_valid", bus.valid, 1'b0);
    check("rst_aluop", bus.aluop, 8'h00);
    check("rst_cnt",   stall_cnt, 16'h0);
    check("rst_ill",   illegal,   1'b0);
    rst = 1'b1;

    // ORI $1,$0,0x8000
    pc = 32'h100; inst = 32'h34018000; if_valid = 1'b1;
    step();
    check("ori_valid", bus.valid, 1'b1);
    check("ori_reg1",  bus.reg1,  32'h0);
    check("ori_reg2",  bus.reg2,  32'h00008000);
    check("ori_wd",    bus.wd,    5'd1);
    check("ori_wreg",  bus.wreg,  1'b1);

    // ADDU $3,$1,$2: EX result beats MEM result
    inst = 32'h00221821;
    ex_wreg = 1'b1; ex_wd = 5'd1; ex_wdata = 32'h11;
    mem_wreg = 1'b1; mem_wd = 5'd1; mem_wdata = 32'h22;
    step();
    check("fwd_reg1", bus.reg1, 32'h11);
    check("fwd_wd",   bus.wd,   5'd3);

    // LW $4 in EX, OR $5,$4,$4 in ID
    quiet_fwd();
    inst = 32'h00842825; ex_wreg = 1'b1; ex_wd = 5'd4; ex_is_load = 1'b1;
    #1 check("lu_ready", id_ready, 1'b0);
    step();
    check("lu_valid", bus.valid, 1'b0);
    check("lu_wreg",  bus.wreg,  1'b0);
    check("lu_cnt",   stall_cnt, 16'd1);
    ex_is_load = 1'b0; ex_wdata = 32'h44;
    #1 check("lu_ready2", id_ready, 1'b1);
    step();
    check("lu_reg1", bus.reg1, 32'h44);
    check("lu_cnt2", stall_cnt, 16'd1);

    // flush kills a valid ORI
    quiet_fwd();
    inst = 32'h34018000; bus.flush = 1'b1;
    step();
    check("fl_valid", bus.valid, 1'b0);
    check("fl_wreg",  bus.wreg,  1'b0);
    bus.flush = 1'b0;

    // hold while EX is not ready
    inst = 32'h34071234;
    step();
    bus.ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      inst = rand_inst(); bus.flush = 1'($urandom_range(0, 1));
      #1 check("hold_ready", id_ready, 1'b0);
      step();
      check("hold_valid", bus.valid, 1'b1);
      check("hold_reg2",  bus.reg2,  32'h1234);
      check("hold_wd",    bus.wd,    5'd7);
    end
    bus.ready = 1'b1; bus.flush = 1'b0;

    // illegal opcode then NOP
    inst = 32'hfc000000;
    step();
    check("ill_pulse", illegal,   1'b1);
    check("ill_valid", bus.valid, 1'b0);
    inst = 32'h0;
    step();
    check("ill_clear", illegal,   1'b0);
    check("nop_valid", bus.valid, 1'b1);
    check("nop_wreg",  bus.wreg,  1'b0);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      inst = rand_inst(); pc = $urandom; if_valid = ($urandom_range(0, 99) < 85);
      bus.ready = ($urandom_range(0, 99) < 80); bus.flush = ($urandom_range(0, 99) < 10);
      ex_wreg = 1'($urandom_range(0, 1)); ex_wd = 5'($urandom_range(0, 7));
      ex_wdata = $urandom; ex_is_load = ($urandom_range(0, 3) == 0);
      mem_wreg = 1'($urandom_range(0, 1)); mem_wd = 5'($urandom_range(0, 7));
      mem_wdata = $urandom;
      if ($urandom_range(0, 15) == 0) rf[$urandom_range(1, 7)] = $urandom;
      step();
    end

    // async reset in the middle of a stall
    quiet_fwd();
    bus.ready = 1'b1; bus.flush = 1'b0; if_valid = 1'b1;
    inst = 32'h00842825; ex_wreg = 1'b1; ex_wd = 5'd4; ex_is_load = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check("ar_cnt",   stall_cnt, 16'h0);
    check("ar_valid", bus.valid, 1'b0);
    check("ar_reg2",  bus.reg2,  32'h0);
    step();
    rst = 1'b1;
    quiet_fwd();
    inst = 32'h34018000;
    repeat (3) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
